// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// adder_ctrl_pkg
// Shared definitions for the nibble-serial adder controller: the sequencer
// state encoding, the width of one adder slice and the default operand size
// in nibbles. Imported by the interface, the adder slice and the controller.
// -----------------------------------------------------------------------------
package adder_ctrl_pkg;

  // Width of one time-shared adder slice.
  localparam int NIBBLE_W    = 4;

  // Default operand width in nibbles.
  localparam int DEF_NIBBLES = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Width of the {cout, sum} result for a given operand size.
  function automatic int result_width(input int nibbles);
    return (NIBBLE_W * nibbles) + 1;
  endfunction

endpackage : adder_ctrl_pkg

// File: rtl/nibble_serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl_if
// Request/result bundle of the nibble-serial adder.
//   start : request, sampled only while the sequencer is idle
//   a, b  : operands, captured on an accepted start
//   cin   : carry-in to nibble 0, captured on an accepted start
//   busy  : high while the nibble loop runs
//   done  : one-cycle pulse, sum/cout valid from this cycle
//   sum   : registered result
//   cout  : registered carry-out of the top nibble
// Modports: master = operand source / result consumer, slave = the adder.
// -----------------------------------------------------------------------------
interface nibble_serial_adder_ctrl_if
  import adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = DEF_NIBBLES
);

  logic                          start;
  logic [NIBBLE_W*NIBBLES-1:0]   a;
  logic [NIBBLE_W*NIBBLES-1:0]   b;
  logic                          cin;
  logic                          busy;
  logic                          done;
  logic [NIBBLE_W*NIBBLES-1:0]   sum;
  logic                          cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface : nibble_serial_adder_ctrl_if

// File: rtl/nibble_serial_adder_ctrl_nibble_add.sv
// -----------------------------------------------------------------------------
// nibble_add
// Purely combinational 4-bit ripple-carry adder slice built from gate-level
// full-adder cells.
//   a, b : slice operands
//   ci   : slice carry-in
//   sum  : slice sum
//   co   : slice carry-out
// -----------------------------------------------------------------------------
module nibble_add (
  output wire [3:0] sum,
  output wire       co,
  input  wire [3:0] a,
  input  wire [3:0] b,
  input  wire       ci
);

  wire [4:0] w_c;
  wire [3:0] w_p;
  wire [3:0] w_g;
  wire [3:0] w_t;

  assign w_c[0] = ci;
  assign co     = w_c[4];

  // One full-adder cell per bit: propagate/generate form, carry rippled upward.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    xor u_xp (w_p[i],   a[i],   b[i]);
    xor u_xs (sum[i],   w_p[i], w_c[i]);
    and u_ag (w_g[i],   a[i],   b[i]);
    and u_at (w_t[i],   w_p[i], w_c[i]);
    or  u_oc (w_c[i+1], w_g[i], w_t[i]);
  end

endmodule : nibble_add

// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Adds two NIBBLES-nibble operands by time-sharing one 4-bit ripple-carry
// slice, one nibble per clock, least-significant nibble first. The carry
// between nibbles is held in a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_adder_ctrl_if
//           (start/a/b/cin in, busy/done/sum/cout out, all outputs registered)
// sum/cout hold the previous result during a new operation and update only on
// the edge that raises done. Reset clears them to 0.
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = DEF_NIBBLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_adder_ctrl_if.slave  bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_RUN  = S_RUN;
  localparam logic [1:0] ST_DONE = S_DONE;

  if (NIBBLES < 2) begin : g_bad_param
    $error("nibble_serial_adder_ctrl: NIBBLES must be at least 2");
  end

  logic [1:0]       r_state;
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_work;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_next_state;
  logic             w_last;
  wire  [3:0]       w_slice_sum;
  wire              w_slice_co;
  logic [W-1:0]     w_work_next;

  // The single shared adder slice, fed from the low nibbles of the operands.
  nibble_add u_nibble_add (
    .sum (w_slice_sum),
    .co  (w_slice_co),
    .a   (r_op_a[NIBBLE_W-1:0]),
    .b   (r_op_b[NIBBLE_W-1:0]),
    .ci  (r_carry)
  );

  // Slice result enters at the top so that after NIBBLES shifts nibble 0
  // has reached the bottom of the working register.
  assign w_last      = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_work_next = {w_slice_sum, r_work[W-1:NIBBLE_W]};

  // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register and registered busy/done flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_RUN);
      r_done  <= (w_next_state == ST_DONE);
    end
  end

  // Operand shift registers, inter-nibble carry, index counter, working sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= {W{1'b0}};
      r_op_b  <= {W{1'b0}};
      r_carry <= 1'b0;
      r_idx   <= {IDX_W{1'b0}};
      r_work  <= {W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op_a  <= bus.a;
            r_op_b  <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= {IDX_W{1'b0}};
            r_work  <= {W{1'b0}};
          end
        end
        ST_RUN: begin
          r_op_a  <= r_op_a >> NIBBLE_W;
          r_op_b  <= r_op_b >> NIBBLE_W;
          r_carry <= w_slice_co;
          r_work  <= w_work_next;
          // Index parks at NIBBLES-1 instead of wrapping.
          if (!w_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          r_idx <= {IDX_W{1'b0}};
        end
        default: begin
          r_idx <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // Result registers: loaded only on the final nibble so they change exactly
  // on the edge that raises done, and hold through the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= {W{1'b0}};
      r_cout <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_sum  <= w_work_next;
      r_cout <= w_slice_co;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule : nibble_serial_adder_ctrl

// File: tb/tb_nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Scoreboard bench: each issued add pushes its expected {cout, sum} computed
// as plain unsigned arithmetic; a monitor pops and compares on every done
// pulse and checks that results hold between done pulses.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  nibble_serial_adder_ctrl_if #(.NIBBLES(N)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0]   sb_q[$];
  logic [W-1:0] held_sum  = '0;
  logic         held_cout = 1'b0;
  int           cyc       = 0;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  // Monitor: compares results on done, checks hold and busy/done exclusivity.
  always @(negedge clk) begin
    logic [W:0] exp;
    cyc++;
    if (!rst_n) begin
      held_sum  = '0;
      held_cout = 1'b0;
    end else begin
      chk("busy_done_exclusive", (W+1)'(bus.busy & bus.done), '0);
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done actual=%h expected=none", {bus.cout, bus.sum});
        end else begin
          exp = sb_q.pop_front();
          chk("result", {bus.cout, bus.sum}, exp);
        end
        held_sum  = bus.sum;
        held_cout = bus.cout;
      end else begin
        chk("result_hold", {bus.cout, bus.sum}, {held_cout, held_sum});
      end
    end
  end

  // Issue one add, optionally poke start again during RUN, and check timing.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input bit poke);
    int c      = 0;
    int busy_n = 0;
    bit got    = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    sb_q.push_back(model(a, b, cin));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom());
    bus.b     = W'($urandom());
    bus.cin   = 1'($urandom());
    while (!got && c < 20) begin
      @(negedge clk);
      c++;
      if (bus.busy) busy_n++;
      if (bus.done) got = 1'b1;
      if (poke && c == 2) bus.start = 1'b1;
      if (poke && c == 3) bus.start = 1'b0;
    end
    chk("done_seen", (W+1)'(got), (W+1)'(1));
    chk("latency", (W+1)'(c), (W+1)'(N + 1));
    chk("busy_cycles", (W+1)'(busy_n), (W+1)'(N));
  endtask

  initial begin
    int k;
    int t_done[3];
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset values.
    #1;
    chk("rst_busy", (W+1)'(bus.busy), '0);
    chk("rst_done", (W+1)'(bus.done), '0);
    chk("rst_result", {bus.cout, bus.sum}, '0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed cases.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0);
    // start re-pulsed during RUN with other operands must be ignored.
    run_op(16'h0F0F, 16'h1111, 1'b0, 1'b1);
    repeat (4) @(negedge clk);

    // Completed add, then reset in the middle of a second one.
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 16'hABCD;
    bus.b     = 16'h1357;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", (W+1)'(bus.busy), '0);
    chk("abort_done", (W+1)'(bus.done), '0);
    chk("abort_result", {bus.cout, bus.sum}, '0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_op(16'h2222, 16'h3333, 1'b1, 1'b0);

    // Randomized adds.
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom()), W'($urandom()), 1'($urandom()), 1'b0);
    end

    // start held high: one result every N+2 cycles.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 16'hC3A5;
    bus.b     = 16'h7E19;
    bus.cin   = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back(model(16'hC3A5, 16'h7E19, 1'b1));
    k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge clk);
      if (bus.done) begin
        t_done[k] = cyc;
        k++;
        if (k == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("hold_start_dones", (W+1)'(k), (W+1)'(3));
    if (k == 3) begin
      chk("hold_start_gap1", (W+1)'(t_done[1] - t_done[0]), (W+1)'(N + 2));
      chk("hold_start_gap2", (W+1)'(t_done[2] - t_done[1]), (W+1)'(N + 2));
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", (W+1)'(sb_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_nibble_serial_adder_ctrl
